param_datapath: RTL and testbench
=================================

Name: param_datapath

Overview:
Parametrised successor to the single-cycle bus datapath: a generic-width register file, HI/LO/Y/Z/PC/MAR/MDR/IR registers, an encoded-safe one-hot bus, and a start/busy/done ALU. Combinational ALU ops complete in one cycle. MUL and DIV are iterative multi-cycle ops.
The block sits under the control unit, which drives every *_in/*_out strobe, and beside memory, which sees mar_q/mdr_q and drives mdata_in.

Parameters:
DATA_W, 32, datapath/bus width (even, >=8)
NUM_REGS, 16, general registers R0..R(NUM_REGS-1)
R0_ZERO, 1, 1: R0 hardwired to 0, writes ignored; 0: R0 is an ordinary register
PC_STEP, 1, increment applied by inc_pc

Ports:
clock  in  1  rising-edge clock
clear  in  1  asynchronous, active-low reset
reg_in  in  NUM_REGS  per-register load strobes
reg_out  in  NUM_REGS  per-register bus-drive strobes
hi_in, lo_in, y_in, pc_in, mar_in, mdr_in, ir_in  in  1 each  load strobes (bus -> reg)
hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out, inport_out  in  1 each  bus-drive strobes
inc_pc  in  1  PC <= PC + PC_STEP
read  in  1  MDR source select: 1 = mdata_in, 0 = bus
mdata_in  in  DATA_W  memory read data
inport_data  in  DATA_W  input-port value
alu_op  in  4  operation code (package enum)
alu_start  in  1  start pulse; operands captured this edge
alu_busy  out  1  multi-cycle op in progress
alu_done  out  1  one-cycle pulse, Z valid
div_by_zero  out  1  sticky, set by DIV with divisor 0
bus_conflict  out  1  sticky, set when >1 source drives the bus
bus_q, mar_q, mdr_q, ir_q  out  DATA_W each  bus value, MAR, MDR, IR

Behaviour:
- Reset (clear=0, async): all registers, Z, PC, flags, alu_busy and alu_done go to 0. An in-flight MUL/DIV is aborted.
- Bus: OR of all enabled sources.
  - No source enabled: bus = 0.
  - More than one source enabled: bus forced to 0 and bus_conflict set at the next edge; it stays set until reset.
- Registers: on a rising edge, each *_in loads bus_q.
  - Several loads in one cycle are all legal.
  - With R0_ZERO=1, R0 reads 0 and reg_in[0] is ignored.
- PC: pc_in has priority over inc_pc. inc_pc wraps modulo 2^DATA_W.
- MDR: mdr_in loads (read ? mdata_in : bus_q).
- ALU operands are captured at the alu_start edge: A = Y, B = bus_q. The bus may change afterwards.
- alu_start while alu_busy=1 is ignored; no restart.
- Single-cycle ops: ADD, SUB, AND, OR, NOT(B), NEG(B), SHR, SHRA, SHL, ROR, ROL.
  - Shift/rotate amount = B[log2(DATA_W)-1:0].
  - Z loaded at the start edge: Zlow = result, Zhigh = sign-extension for ADD/SUB/NEG, else 0.
  - alu_done=1 for the following cycle; alu_busy never rises.
- MUL: signed radix-2 Booth, DATA_W iterations.
  - alu_busy=1 from the edge after start for DATA_W cycles.
  - Z = {Zhigh, Zlow} = 2*DATA_W signed product.
  - alu_done pulses in the cycle busy falls (latency DATA_W+1 edges).
- DIV: signed restoring divide, same timing as MUL.
  - Zlow = quotient (truncated toward zero), Zhigh = remainder (sign of dividend).
  - Divisor 0: Zlow = all ones, Zhigh = dividend, div_by_zero set.
- Z changes only on ALU completion. zhigh_out/zlow_out drive the latched Z.
- Illegal alu_op: Z = 0, done after one cycle.
- FSM: IDLE -> (start & MUL/DIV) RUN -> (count == DATA_W-1) DONE -> IDLE. DONE lasts one cycle and drives alu_done. A single-cycle op goes IDLE -> DONE.

Decomposition:
- Package dp_pkg holds:
  - alu_op enum: ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHRA=5, SHL=6, ROR=7, ROL=8, MUL=9, DIV=10, NEG=11, NOT=12.
  - ALU FSM state enum.
  - Function clog2 for the shift/count width.
- Sub-module iter_muldiv (DATA_W parameter): start/op/a/b in; busy/done/hi/lo/dz out. It holds the counter and shift registers.
- The top level holds the bus, register file, combinational ALU and FSM.

Test Plan:
1. Reset mid-op: reset during MUL busy -> busy=0, done never pulses, Z=0, PC=0.
2. Register path: DATA_W=32. Bus from inport_data=0x0000_0005 into R2, then R2->Y, R3=0x0000_0003 on bus, start ADD -> Zlow=8, Zhigh=0, done 1 cycle later.
3. MUL: Y=-7 (0xFFFF_FFF9), bus 6, start MUL -> busy for 32 cycles, then Zhigh=0xFFFF_FFFF, Zlow=0xFFFF_FFD6. A second start during busy is ignored.
4. DIV:
   - -17 / 5 -> Zlow=0xFFFF_FFFD (-3), Zhigh=0xFFFF_FFFE (-2).
   - 9 / 0 -> Zlow=0xFFFF_FFFF, Zhigh=9, div_by_zero=1.
5. Bus and R0:
   - reg_out[1] and reg_out[2] both high -> bus_q=0, bus_conflict=1 and stays 1.
   - With R0_ZERO=1, reg_in[0] with bus 0x1234 -> R0 still reads 0.
6. PC, MDR and shifts:
   - PC=0xFFFF_FFFF with inc_pc -> 0.
   - pc_in and inc_pc together with bus 0x40 -> PC=0x40.
   - read=1, mdr_in, mdata_in=0xCAFE -> mdr_q=0xCAFE.
   - ROR Y=0x8000_0001 by 1 -> 0xC000_0000.
   - SHRA 0x8000_0000 by 4 -> 0xF800_0000.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared types and helpers for the parametrised bus datapath.
// ALU opcodes, ALU sequencer states and a constant-foldable ceil(log2).
package dp_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SHR  = 4'd4,
        OP_SHRA = 4'd5,
        OP_SHL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_ROL  = 4'd8,
        OP_MUL  = 4'd9,
        OP_DIV  = 4'd10,
        OP_NEG  = 4'd11,
        OP_NOT  = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative signed multiply (radix-2 Booth) and signed restoring divide.
// One step per clock for DATA_W clocks; hi/lo show the result of the step in progress.
module iter_muldiv
    import dp_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic              op_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              dz
);

    localparam int CW = clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic              r_busy;
    logic [CW-1:0]     r_cnt;
    logic              r_div;
    logic [DATA_W:0]   r_acc;
    logic [DATA_W-1:0] r_q;
    logic              r_q1;
    logic [DATA_W-1:0] r_m;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_dz;
    logic [DATA_W-1:0] r_dvd;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_rs;
    logic [DATA_W:0]   w_acc_nx;
    logic [DATA_W-1:0] w_q_nx;
    logic              w_q1_nx;
    logic [DATA_W-1:0] w_rem;

    // Divide works on magnitudes; signs are restored on the way out.
    always_comb begin
        w_sum    = r_acc;
        w_rs     = '0;
        w_acc_nx = r_acc;
        w_q_nx   = r_q;
        w_q1_nx  = r_q1;
        if (r_div) begin
            w_rs = {r_acc[DATA_W-1:0], r_q[DATA_W-1]};
            if (w_rs >= {1'b0, r_m}) begin
                w_acc_nx = w_rs - {1'b0, r_m};
                w_q_nx   = {r_q[DATA_W-2:0], 1'b1};
            end else begin
                w_acc_nx = w_rs;
                w_q_nx   = {r_q[DATA_W-2:0], 1'b0};
            end
        end else begin
            case ({r_q[0], r_q1})
                2'b01:   w_sum = r_acc + {r_m[DATA_W-1], r_m};
                2'b10:   w_sum = r_acc - {r_m[DATA_W-1], r_m};
                default: w_sum = r_acc;
            endcase
            w_acc_nx = {w_sum[DATA_W], w_sum[DATA_W:1]};
            w_q_nx   = {w_sum[0], r_q[DATA_W-1:1]};
            w_q1_nx  = r_q[0];
        end
    end

    always_comb begin
        w_rem = w_acc_nx[DATA_W-1:0];
        hi    = w_rem;
        lo    = w_q_nx;
        if (r_div) begin
            if (r_dz) begin
                hi = r_dvd;
                lo = '1;
            end else begin
                hi = r_neg_r ? -w_rem : w_rem;
                lo = r_neg_q ? -w_q_nx : w_q_nx;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_acc   <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_m     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_dvd   <= '0;
        end else if (!r_busy) begin
            if (start) begin
                r_busy  <= 1'b1;
                r_cnt   <= '0;
                r_div   <= op_div;
                r_acc   <= '0;
                r_q1    <= 1'b0;
                r_dvd   <= a;
                r_dz    <= op_div && (b == '0);
                r_neg_q <= a[DATA_W-1] ^ b[DATA_W-1];
                r_neg_r <= a[DATA_W-1];
                if (op_div) begin
                    r_q <= a[DATA_W-1] ? -a : a;
                    r_m <= b[DATA_W-1] ? -b : b;
                end else begin
                    r_q <= b;
                    r_m <= a;
                end
            end
        end else begin
            r_acc <= w_acc_nx;
            r_q   <= w_q_nx;
            r_q1  <= w_q1_nx;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) r_busy <= 1'b0;
        end
    end

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == LAST);
    assign dz   = r_dz;

endmodule

// File: rtl/param_datapath.sv
// Bus datapath: register file, special registers, one-hot-checked bus and start/busy/done ALU.
// ALU sequencer states:
//   ST_IDLE | no operation pending; alu_start accepted
//   ST_RUN  | MUL/DIV iterating in iter_muldiv; alu_start ignored
//   ST_DONE | one cycle, Z valid, alu_done high; alu_start accepted again
module param_datapath
    import dp_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int R0_ZERO  = 1,
    parameter int PC_STEP  = 1
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [NUM_REGS-1:0] reg_in,
    input  logic [NUM_REGS-1:0] reg_out,
    input  logic                hi_in,
    input  logic                lo_in,
    input  logic                y_in,
    input  logic                pc_in,
    input  logic                mar_in,
    input  logic                mdr_in,
    input  logic                ir_in,
    input  logic                hi_out,
    input  logic                lo_out,
    input  logic                zhigh_out,
    input  logic                zlow_out,
    input  logic                pc_out,
    input  logic                mdr_out,
    input  logic                inport_out,
    input  logic                inc_pc,
    input  logic                read,
    input  logic [DATA_W-1:0]   mdata_in,
    input  logic [DATA_W-1:0]   inport_data,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic                alu_start,
    output logic                alu_busy,
    output logic                alu_done,
    output logic                div_by_zero,
    output logic                bus_conflict,
    output logic [DATA_W-1:0]   bus_q,
    output logic [DATA_W-1:0]   mar_q,
    output logic [DATA_W-1:0]   mdr_q,
    output logic [DATA_W-1:0]   ir_q
);

    localparam int SW = clog2(DATA_W);
    localparam int NSRC = NUM_REGS + 7;
    localparam logic [SW:0] W_SH = (SW+1)'(DATA_W);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_hi, r_lo, r_y, r_zhi, r_zlo, r_pc, r_mar, r_mdr, r_ir;
    logic              r_bus_conflict, r_div_by_zero;
    alu_state_e        r_state, w_state_nx;

    logic [DATA_W-1:0] w_src [NSRC];
    logic [NSRC-1:0]   w_src_en;
    logic [DATA_W-1:0] w_bus_or;
    logic              w_multi, w_seen;

    logic [DATA_W-1:0] w_alu_hi, w_alu_lo;
    logic [DATA_W:0]   w_ext;
    logic [SW-1:0]     w_sh;
    logic [SW:0]       w_shamt;
    logic              w_is_md, w_accept, w_md_start;
    logic              w_md_busy, w_md_done, w_md_dz;
    logic [DATA_W-1:0] w_md_hi, w_md_lo;

    // Any second driver blanks the bus rather than letting values OR together.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_src[i] = (R0_ZERO != 0 && i == 0) ? '0 : r_regs[i];
        end
        w_src[NUM_REGS+0] = r_hi;
        w_src[NUM_REGS+1] = r_lo;
        w_src[NUM_REGS+2] = r_zhi;
        w_src[NUM_REGS+3] = r_zlo;
        w_src[NUM_REGS+4] = r_pc;
        w_src[NUM_REGS+5] = r_mdr;
        w_src[NUM_REGS+6] = inport_data;
        w_src_en = {inport_out, mdr_out, pc_out, zlow_out, zhigh_out, lo_out, hi_out, reg_out};
        w_bus_or = '0;
        w_multi  = 1'b0;
        w_seen   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_src_en[i]) begin
                w_bus_or = w_bus_or | w_src[i];
                w_multi  = w_multi | w_seen;
                w_seen   = 1'b1;
            end
        end
    end

    assign bus_q = w_multi ? '0 : w_bus_or;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_y   <= '0;
            r_pc  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_ir  <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_in[i] && !(R0_ZERO != 0 && i == 0)) r_regs[i] <= bus_q;
            end
            if (hi_in)  r_hi  <= bus_q;
            if (lo_in)  r_lo  <= bus_q;
            if (y_in)   r_y   <= bus_q;
            if (mar_in) r_mar <= bus_q;
            if (ir_in)  r_ir  <= bus_q;
            if (mdr_in) r_mdr <= read ? mdata_in : bus_q;
            if (pc_in)       r_pc <= bus_q;
            else if (inc_pc) r_pc <= r_pc + DATA_W'(PC_STEP);
        end
    end

    // Rotate amounts are folded into 0..DATA_W-1 for non-power-of-two widths.
    always_comb begin
        w_alu_hi = '0;
        w_alu_lo = '0;
        w_ext    = '0;
        w_sh     = bus_q[SW-1:0];
        w_shamt  = {1'b0, w_sh};
        if (w_shamt >= W_SH) w_shamt = w_shamt - W_SH;
        case (alu_op)
            OP_ADD: begin
                w_ext    = {r_y[DATA_W-1], r_y} + {bus_q[DATA_W-1], bus_q};
                w_alu_lo = w_ext[DATA_W-1:0];
                w_alu_hi = {DATA_W{w_ext[DATA_W]}};
            end
            OP_SUB: begin
                w_ext    = {r_y[DATA_W-1], r_y} - {bus_q[DATA_W-1], bus_q};
                w_alu_lo = w_ext[DATA_W-1:0];
                w_alu_hi = {DATA_W{w_ext[DATA_W]}};
            end
            OP_NEG: begin
                w_ext    = '0 - {bus_q[DATA_W-1], bus_q};
                w_alu_lo = w_ext[DATA_W-1:0];
                w_alu_hi = {DATA_W{w_ext[DATA_W]}};
            end
            OP_AND:  w_alu_lo = r_y & bus_q;
            OP_OR:   w_alu_lo = r_y | bus_q;
            OP_NOT:  w_alu_lo = ~bus_q;
            OP_SHR:  w_alu_lo = r_y >> w_sh;
            OP_SHRA: w_alu_lo = $signed(r_y) >>> w_sh;
            OP_SHL:  w_alu_lo = r_y << w_sh;
            OP_ROR:  w_alu_lo = (r_y >> w_shamt) | (r_y << (W_SH - w_shamt));
            OP_ROL:  w_alu_lo = (r_y << w_shamt) | (r_y >> (W_SH - w_shamt));
            default: begin
                w_alu_hi = '0;
                w_alu_lo = '0;
            end
        endcase
    end

    assign w_is_md = (alu_op == OP_MUL) || (alu_op == OP_DIV);

    iter_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clock  (clock),
        .clear  (clear),
        .start  (w_md_start),
        .op_div (alu_op == OP_DIV),
        .a      (r_y),
        .b      (bus_q),
        .busy   (w_md_busy),
        .done   (w_md_done),
        .hi     (w_md_hi),
        .lo     (w_md_lo),
        .dz     (w_md_dz)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_md_start = 1'b0;
        alu_busy   = 1'b0;
        alu_done   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                alu_done   = (r_state == ST_DONE);
                w_state_nx = ST_IDLE;
                if (alu_start) begin
                    w_accept = 1'b1;
                    if (w_is_md) begin
                        w_md_start = 1'b1;
                        w_state_nx = ST_RUN;
                    end else begin
                        w_state_nx = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                alu_busy = 1'b1;
                if (w_md_done || !w_md_busy) w_state_nx = ST_DONE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_zhi          <= '0;
            r_zlo          <= '0;
            r_div_by_zero  <= 1'b0;
            r_bus_conflict <= 1'b0;
        end else begin
            if (w_accept && !w_is_md) begin
                r_zhi <= w_alu_hi;
                r_zlo <= w_alu_lo;
            end else if (r_state == ST_RUN && w_md_done) begin
                r_zhi <= w_md_hi;
                r_zlo <= w_md_lo;
                if (w_md_dz) r_div_by_zero <= 1'b1;
            end
            if (w_multi) r_bus_conflict <= 1'b1;
        end
    end

    assign div_by_zero  = r_div_by_zero;
    assign bus_conflict = r_bus_conflict;
    assign mar_q        = r_mar;
    assign mdr_q        = r_mdr;
    assign ir_q         = r_ir;

endmodule

// File: tb/tb_param_datapath.sv
// Directed bench for param_datapath with a scoreboard on ALU completions.
module tb_param_datapath;
    import dp_pkg::*;

    localparam int W = 32;
    localparam int NR = 16;

    logic          clock = 1'b0;
    logic          clear;
    logic [NR-1:0] reg_in, reg_out;
    logic          hi_in, lo_in, y_in, pc_in, mar_in, mdr_in, ir_in;
    logic          hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out, inport_out;
    logic          inc_pc, read;
    logic [W-1:0]  mdata_in, inport_data;
    logic [3:0]    alu_op;
    logic          alu_start;
    logic          alu_busy, alu_done, div_by_zero, bus_conflict;
    logic [W-1:0]  bus_q, mar_q, mdr_q, ir_q;

    param_datapath #(.DATA_W(W), .NUM_REGS(NR), .R0_ZERO(1), .PC_STEP(1)) dut (
        .clock(clock), .clear(clear), .reg_in(reg_in), .reg_out(reg_out),
        .hi_in(hi_in), .lo_in(lo_in), .y_in(y_in), .pc_in(pc_in), .mar_in(mar_in),
        .mdr_in(mdr_in), .ir_in(ir_in), .hi_out(hi_out), .lo_out(lo_out),
        .zhigh_out(zhigh_out), .zlow_out(zlow_out), .pc_out(pc_out), .mdr_out(mdr_out),
        .inport_out(inport_out), .inc_pc(inc_pc), .read(read), .mdata_in(mdata_in),
        .inport_data(inport_data), .alu_op(alu_op), .alu_start(alu_start),
        .alu_busy(alu_busy), .alu_done(alu_done), .div_by_zero(div_by_zero),
        .bus_conflict(bus_conflict), .bus_q(bus_q), .mar_q(mar_q), .mdr_q(mdr_q), .ir_q(ir_q)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        string       nm;
        logic [31:0] hi;
        logic [31:0] lo;
        int          start;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic idle();
        reg_in = '0; reg_out = '0;
        hi_in = 0; lo_in = 0; y_in = 0; pc_in = 0; mar_in = 0; mdr_in = 0; ir_in = 0;
        hi_out = 0; lo_out = 0; zhigh_out = 0; zlow_out = 0; pc_out = 0; mdr_out = 0;
        inport_out = 0; inc_pc = 0; read = 0; alu_start = 0;
    endtask

    task automatic tick();
        @(posedge clock); #1;
        idle();
    endtask

    task automatic load_y(input logic [31:0] v);
        inport_data = v; inport_out = 1; y_in = 1;
        tick();
    endtask

    // Issue one ALU op with B from inport (src_reg<0) or register src_reg; hold Z on the bus.
    task automatic alu_go(input string nm, input logic [3:0] op, input int src_reg,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                          input int lat, input bit poke);
        int nb;
        int k;
        if (src_reg >= 0) reg_out = NR'(1) << src_reg;
        else begin inport_data = b; inport_out = 1; end
        alu_op = op; alu_start = 1;
        @(posedge clock); #1;
        idle();
        zlow_out = 1;
        sb.push_back('{nm, hi, lo, cyc, lat});
        nb = int'(alu_busy);
        k = 0;
        while (!alu_done && k < 200) begin
            if (poke && k == 5) begin alu_start = 1; alu_op = OP_ADD; end
            else alu_start = 0;
            @(posedge clock); #1;
            nb += int'(alu_busy);
            k++;
        end
        alu_start = 0;
        if (!alu_done) begin
            total++; bad++;
            $display("FAIL %s_timeout: no alu_done within 200 cycles", nm);
            sb.delete();
        end
        check({nm, "_busy_cycles"}, nb, lat);
        @(posedge clock); #1;
        zlow_out = 0; zhigh_out = 1;
        @(posedge clock); #1;
        zhigh_out = 0;
    endtask

    // Monitor: on each alu_done compare latency, Zlow now, Zhigh the next cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (clear && alu_done) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: alu_done=1 with empty scoreboard at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.nm, "_latency"}, cyc, e.start + e.lat);
                    check({e.nm, "_zlow"}, bus_q, e.lo);
                    @(negedge clock);
                    check({e.nm, "_zhigh"}, bus_q, e.hi);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int nb;
        clear = 0;
        idle();
        alu_op = OP_ADD; inport_data = '0; mdata_in = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_bus", bus_q, 0);
        check("rst_mar", mar_q, 0);
        check("rst_mdr", mdr_q, 0);
        check("rst_ir", ir_q, 0);
        check("rst_busy_done", {alu_busy, alu_done}, 0);
        check("rst_flags", {div_by_zero, bus_conflict}, 0);
        clear = 1;
        tick();

        // register path and ADD
        inport_data = 5; inport_out = 1; reg_in = NR'(1) << 2; tick();
        inport_data = 3; inport_out = 1; reg_in = NR'(1) << 3; tick();
        reg_out = NR'(1) << 2; #1; check("r2_read", bus_q, 5);
        y_in = 1; tick();
        alu_go("add", OP_ADD, 3, 0, 32'h0, 32'h8, 0, 0);

        // multiply, with an ignored restart during busy
        load_y(32'hFFFF_FFF9);
        alu_go("mul_neg", OP_MUL, -1, 6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 32, 1);
        load_y(32'hFFFF_FFFF);
        alu_go("mul_m1", OP_MUL, -1, 32'hFFFF_FFFF, 32'h0, 32'h1, 32, 0);

        // divide
        load_y(32'hFFFF_FFEF);
        alu_go("div_m17_5", OP_DIV, -1, 5, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, 0);
        check("dz_clear", div_by_zero, 0);
        load_y(17);
        alu_go("div_17_m5", OP_DIV, -1, 32'hFFFF_FFFB, 32'h2, 32'hFFFF_FFFD, 32, 0);
        load_y(9);
        alu_go("div_by0", OP_DIV, -1, 0, 32'h9, 32'hFFFF_FFFF, 32, 0);
        check("dz_set", div_by_zero, 1);

        // reset in the middle of a multiply
        inport_data = 32'h55; inport_out = 1; pc_in = 1; tick();
        load_y(3);
        inport_data = 5; inport_out = 1; alu_op = OP_MUL; alu_start = 1; tick();
        repeat (5) @(posedge clock);
        #3;
        clear = 0;
        #1;
        check("rst_mid_busy_done", {alu_busy, alu_done}, 0);
        zlow_out = 1; #1; check("rst_mid_zlow", bus_q, 0); zlow_out = 0;
        zhigh_out = 1; #1; check("rst_mid_zhigh", bus_q, 0); zhigh_out = 0;
        pc_out = 1; #1; check("rst_mid_pc", bus_q, 0); pc_out = 0;
        check("rst_mid_dz", div_by_zero, 0);
        sb.delete();
        @(posedge clock); #1;
        clear = 1;
        nd = 0; nb = 0;
        repeat (40) begin
            @(posedge clock); #1;
            nd += int'(alu_done);
            nb += int'(alu_busy);
        end
        check("rst_mid_no_done", nd, 0);
        check("rst_mid_no_busy", nb, 0);

        // PC, MDR, MAR, IR
        inport_data = 32'hFFFF_FFFF; inport_out = 1; pc_in = 1; tick();
        inc_pc = 1; tick();
        pc_out = 1; #1; check("pc_wrap", bus_q, 0); pc_out = 0;
        inport_data = 32'h40; inport_out = 1; pc_in = 1; inc_pc = 1; tick();
        pc_out = 1; #1; check("pc_in_prio", bus_q, 32'h40); pc_out = 0;
        inc_pc = 1; tick();
        pc_out = 1; #1; check("pc_inc", bus_q, 32'h41); pc_out = 0;
        read = 1; mdr_in = 1; mdata_in = 32'hCAFE; tick();
        check("mdr_mem", mdr_q, 32'hCAFE);
        inport_data = 32'h77; inport_out = 1; mdr_in = 1; tick();
        check("mdr_bus", mdr_q, 32'h77);
        inport_data = 32'h100; inport_out = 1; mar_in = 1; tick();
        check("mar", mar_q, 32'h100);
        inport_data = 32'hDEAD_BEEF; inport_out = 1; ir_in = 1; tick();
        check("ir", ir_q, 32'hDEAD_BEEF);

        // single-cycle ops
        load_y(32'h8000_0001);
        alu_go("ror", OP_ROR, -1, 1, 32'h0, 32'hC000_0000, 0, 0);
        alu_go("rol", OP_ROL, -1, 4, 32'h0, 32'h0000_0018, 0, 0);
        load_y(32'h8000_0000);
        alu_go("shra", OP_SHRA, -1, 4, 32'h0, 32'hF800_0000, 0, 0);
        alu_go("shr", OP_SHR, -1, 4, 32'h0, 32'h0800_0000, 0, 0);
        load_y(1);
        alu_go("shl", OP_SHL, -1, 31, 32'h0, 32'h8000_0000, 0, 0);
        load_y(32'h0000_F0F0);
        alu_go("and", OP_AND, -1, 32'hFF00, 32'h0, 32'h0000_F000, 0, 0);
        alu_go("or", OP_OR, -1, 32'hFF00, 32'h0, 32'h0000_FFF0, 0, 0);
        alu_go("not", OP_NOT, -1, 32'h0000_FFFF, 32'h0, 32'hFFFF_0000, 0, 0);
        alu_go("neg", OP_NEG, -1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0, 0);
        load_y(3);
        alu_go("sub", OP_SUB, -1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
        alu_go("illegal", 4'd13, -1, 5, 32'h0, 32'h0, 0, 0);

        // R0 and bus conflict
        check("conflict_clear", bus_conflict, 0);
        inport_data = 32'h1234; inport_out = 1; reg_in = NR'(1); tick();
        reg_out = NR'(1); #1; check("r0_zero", bus_q, 0); reg_out = '0;
        inport_data = 32'h11; inport_out = 1; reg_in = NR'(1) << 1; tick();
        inport_data = 32'h22; inport_out = 1; reg_in = NR'(1) << 2; tick();
        reg_out = NR'(6); #1; check("conflict_bus", bus_q, 0);
        tick();
        check("conflict_set", bus_conflict, 1);
        repeat (3) tick();
        check("conflict_sticky", bus_conflict, 1);
        reg_out = NR'(1) << 1; #1; check("r1_read", bus_q, 32'h11); reg_out = '0;

        repeat (2) tick();
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
